// File: rtl/mem_stage.sv
// mem_stage: load/store over req/ack bus with timeout; ports: EX/MEM inputs, bus_* master, stall_o, registered WB outputs, align/bus error pulses
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] result_i,
  input  logic [4:0]  writeAddr_i,
  input  logic        writeEnable_i,
  input  logic [3:0]  memOp_i,
  input  logic [31:0] storeData_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        stall_o,
  output logic [31:0] result_o,
  output logic [4:0]  writeAddr_o,
  output logic        writeEnable_o,
  output logic        align_err_o,
  output logic        bus_err_o,
  output logic [31:0] bad_addr_o
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_n;
  logic [3:0]  op_q;
  logic [31:0] addr_q;
  logic [4:0]  wa_q;
  logic        we_q;
  logic [7:0]  cnt;
  logic        is_mem, is_byte, is_half, is_word, misaligned, mem_go, timeout;
  logic [3:0]  be_n;
  logic [31:0] wdata_n, load_data;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  always_comb begin
    is_mem = memOp_i >= 4'd1 && memOp_i <= 4'd8;
    is_byte = memOp_i == 4'd1 || memOp_i == 4'd2 || memOp_i == 4'd6;
    is_half = memOp_i == 4'd3 || memOp_i == 4'd4 || memOp_i == 4'd7;
    is_word = memOp_i == 4'd5 || memOp_i == 4'd8;
    misaligned = (is_half && result_i[0]) || (is_word && result_i[1:0] != 2'b00);
    mem_go = is_mem && !misaligned;
    be_n = is_byte ? 4'b0001 << result_i[1:0] : is_half ? (result_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_n = is_byte ? {4{storeData_i[7:0]}} : is_half ? {2{storeData_i[15:0]}} : storeData_i;
    timeout = cnt == 8'(TIMEOUT - 1);
    byte_v = bus_rdata_i[8*addr_q[1:0] +: 8];
    half_v = addr_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    load_data = op_q == 4'd1 ? {{24{byte_v[7]}}, byte_v} :
                op_q == 4'd2 ? {24'b0, byte_v} :
                op_q == 4'd3 ? {{16{half_v[15]}}, half_v} :
                op_q == 4'd4 ? {16'b0, half_v} : bus_rdata_i;
    stall_o = state == IDLE ? mem_go : !bus_ack_i;
    state_n = state == IDLE ? (mem_go ? WAIT : IDLE) : ((bus_ack_i || timeout) ? IDLE : WAIT);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_q <= '0;
      addr_q <= '0;
      wa_q <= '0;
      we_q <= 1'b0;
      cnt <= '0;
      bus_req_o <= 1'b0;
      bus_we_o <= 1'b0;
      bus_addr_o <= '0;
      bus_be_o <= '0;
      bus_wdata_o <= '0;
      result_o <= '0;
      writeAddr_o <= '0;
      writeEnable_o <= 1'b0;
      align_err_o <= 1'b0;
      bus_err_o <= 1'b0;
      bad_addr_o <= '0;
    end else begin
      state <= state_n;
      align_err_o <= 1'b0;
      bus_err_o <= 1'b0;
      if (state == IDLE) begin
        if (!is_mem) begin
          result_o <= result_i;
          writeAddr_o <= writeAddr_i;
          writeEnable_o <= writeEnable_i;
        end else if (misaligned) begin
          writeEnable_o <= 1'b0;
          align_err_o <= 1'b1;
          bad_addr_o <= result_i;
        end else begin
          op_q <= memOp_i;
          addr_q <= result_i;
          wa_q <= writeAddr_i;
          we_q <= writeEnable_i;
          cnt <= '0;
          bus_req_o <= 1'b1;
          bus_we_o <= memOp_i >= 4'd6;
          bus_addr_o <= {result_i[31:2], 2'b00};
          bus_be_o <= be_n;
          bus_wdata_o <= wdata_n;
          writeEnable_o <= 1'b0;
        end
      end else if (bus_ack_i) begin
        bus_req_o <= 1'b0;
        if (!bus_we_o) begin
          result_o <= load_data;
          writeAddr_o <= wa_q;
          writeEnable_o <= we_q;
        end else
          writeEnable_o <= 1'b0;
      end else if (timeout) begin
        bus_req_o <= 1'b0;
        bus_err_o <= 1'b1;
        bad_addr_o <= addr_q;
        writeEnable_o <= 1'b0;
      end else begin
        cnt <= cnt + 8'd1;
        writeEnable_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] result_i, storeData_i, bus_rdata_i;
  logic [4:0]  writeAddr_i;
  logic        writeEnable_i, bus_ack_i;
  logic [3:0]  memOp_i;
  logic        bus_req_o, bus_we_o, stall_o, writeEnable_o, align_err_o, bus_err_o;
  logic [31:0] bus_addr_o, bus_wdata_o, result_o, bad_addr_o;
  logic [3:0]  bus_be_o;
  logic [4:0]  writeAddr_o;
  int checks = 0;
  int failures = 0;
  mem_stage #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .result_i(result_i), .writeAddr_i(writeAddr_i),
    .writeEnable_i(writeEnable_i), .memOp_i(memOp_i), .storeData_i(storeData_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
    .bus_ack_i(bus_ack_i), .stall_o(stall_o), .result_o(result_o),
    .writeAddr_o(writeAddr_o), .writeEnable_o(writeEnable_o),
    .align_err_o(align_err_o), .bus_err_o(bus_err_o), .bad_addr_o(bad_addr_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_op(input logic [3:0] op, input logic [31:0] addr, input logic [4:0] wa, input logic we, input logic [31:0] sd);
    memOp_i = op;
    result_i = addr;
    writeAddr_i = wa;
    writeEnable_i = we;
    storeData_i = sd;
  endtask
  task automatic load_access(input string tag, input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rdata,
                             input int waits, input logic [31:0] exp_addr, input logic [3:0] exp_be, input logic [31:0] exp);
    set_op(op, addr, 5'd9, 1'b1, 32'h0);
    bus_rdata_i = rdata;
    #1;
    chk({tag, "_stall_idle"}, stall_o, 1);
    tick;
    chk({tag, "_req"}, bus_req_o, 1);
    chk({tag, "_addr"}, bus_addr_o, exp_addr);
    chk({tag, "_be"}, bus_be_o, exp_be);
    chk({tag, "_we_bus"}, bus_we_o, 0);
    chk({tag, "_bubble"}, writeEnable_o, 0);
    for (int i = 1; i < waits; i++) begin
      chk({tag, "_stall_wait"}, stall_o, 1);
      chk({tag, "_no_err"}, bus_err_o, 0);
      tick;
    end
    bus_ack_i = 1'b1;
    #1;
    chk({tag, "_stall_ack"}, stall_o, 0);
    tick;
    bus_ack_i = 1'b0;
    set_op(4'd0, 32'h0, 5'd0, 1'b0, 32'h0);
    chk({tag, "_result"}, result_o, exp);
    chk({tag, "_wen"}, writeEnable_o, 1);
    chk({tag, "_waddr"}, writeAddr_o, 9);
    chk({tag, "_req_drop"}, bus_req_o, 0);
    chk({tag, "_bus_err"}, bus_err_o, 0);
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_result"}, result_o, 0);
    chk({tag, "_waddr"}, writeAddr_o, 0);
    chk({tag, "_wen"}, writeEnable_o, 0);
    chk({tag, "_req"}, bus_req_o, 0);
    chk({tag, "_bwe"}, bus_we_o, 0);
    chk({tag, "_baddr"}, bus_addr_o, 0);
    chk({tag, "_be"}, bus_be_o, 0);
    chk({tag, "_wdata"}, bus_wdata_o, 0);
    chk({tag, "_align"}, align_err_o, 0);
    chk({tag, "_berr"}, bus_err_o, 0);
    chk({tag, "_bad"}, bad_addr_o, 0);
  endtask
  initial begin
    rst = 1'b1;
    bus_ack_i = 1'b0;
    bus_rdata_i = 32'h0;
    set_op(4'd0, 32'h0, 5'd0, 1'b0, 32'h0);
    tick;
    tick;
    chk_all_zero("reset");
    rst = 1'b0;
    set_op(4'd0, 32'h1234_5678, 5'd3, 1'b1, 32'h0);
    #1;
    chk("nop_stall", stall_o, 0);
    tick;
    chk("nop_result", result_o, 32'h1234_5678);
    chk("nop_waddr", writeAddr_o, 3);
    chk("nop_wen", writeEnable_o, 1);
    load_access("lb", 4'd1, 32'h0000_1003, 32'h80FF_0011, 1, 32'h0000_1000, 4'b1000, 32'hFFFF_FF80);
    load_access("lbu", 4'd2, 32'h0000_1003, 32'h80FF_0011, 1, 32'h0000_1000, 4'b1000, 32'h0000_0080);
    load_access("lh", 4'd3, 32'h0000_5002, 32'h8001_1234, 2, 32'h0000_5000, 4'b1100, 32'hFFFF_8001);
    load_access("lhu", 4'd4, 32'h0000_5000, 32'h8001_9234, 1, 32'h0000_5000, 4'b0011, 32'h0000_9234);
    set_op(4'd7, 32'h0000_2002, 5'd4, 1'b0, 32'hAAAA_BEEF);
    #1;
    chk("sh_stall_idle", stall_o, 1);
    tick;
    for (int i = 1; i <= 3; i++) begin
      chk("sh_req", bus_req_o, 1);
      chk("sh_bwe", bus_we_o, 1);
      chk("sh_addr", bus_addr_o, 32'h0000_2000);
      chk("sh_be", bus_be_o, 4'b1100);
      chk("sh_wdata", bus_wdata_o, 32'hBEEF_BEEF);
      if (i == 3) bus_ack_i = 1'b1;
      #1;
      chk("sh_stall", stall_o, (i == 3) ? 0 : 1);
      tick;
    end
    bus_ack_i = 1'b0;
    set_op(4'd0, 32'h0, 5'd0, 1'b0, 32'h0);
    chk("sh_wen", writeEnable_o, 0);
    chk("sh_req_drop", bus_req_o, 0);
    set_op(4'd5, 32'h0000_3001, 5'd6, 1'b1, 32'h0);
    #1;
    chk("mis_stall", stall_o, 0);
    tick;
    chk("mis_req", bus_req_o, 0);
    chk("mis_align", align_err_o, 1);
    chk("mis_bad", bad_addr_o, 32'h0000_3001);
    chk("mis_wen", writeEnable_o, 0);
    set_op(4'd0, 32'h0, 5'd0, 1'b0, 32'h0);
    tick;
    chk("mis_pulse", align_err_o, 0);
    chk("mis_bad_hold", bad_addr_o, 32'h0000_3001);
    set_op(4'd5, 32'h0000_4000, 5'd7, 1'b1, 32'h0);
    tick;
    for (int i = 1; i <= 16; i++) begin
      chk("to_req", bus_req_o, 1);
      chk("to_no_err", bus_err_o, 0);
      chk("to_stall", stall_o, 1);
      tick;
    end
    chk("to_err", bus_err_o, 1);
    chk("to_req_drop", bus_req_o, 0);
    chk("to_bad", bad_addr_o, 32'h0000_4000);
    chk("to_wen", writeEnable_o, 0);
    set_op(4'd0, 32'h0, 5'd0, 1'b0, 32'h0);
    #1;
    chk("to_idle_stall", stall_o, 0);
    tick;
    chk("to_pulse", bus_err_o, 0);
    load_access("lw16", 4'd5, 32'h0000_4004, 32'hCAFE_F00D, 16, 32'h0000_4004, 4'b1111, 32'hCAFE_F00D);
    set_op(4'd5, 32'h0000_6000, 5'd8, 1'b1, 32'h0);
    bus_rdata_i = 32'hDEAD_BEEF;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    set_op(4'd0, 32'h0, 5'd0, 1'b0, 32'h0);
    chk_all_zero("midrst");
    bus_ack_i = 1'b1;
    tick;
    bus_ack_i = 1'b0;
    chk("late_ack_result", result_o, 0);
    chk("late_ack_wen", writeEnable_o, 0);
    chk("late_ack_req", bus_req_o, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
